// File: rtl/endp_flit_injector.sv
// Endpoint-to-router packet injector: serializes packet requests plus payload
// words into head/body/tail flits, with per-VC credit flow control.

// One credit counter per VC. Sends and returns in the same cycle cancel out.
module endp_credit_cnt #(
  parameter int B  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          send,
  input  logic          ret,
  output logic [CW-1:0] count,
  output logic          ovf
);
  localparam logic [CW-1:0] FULL = CW'(B);

  // A return with the counter already full is a protocol error from the router.
  assign ovf = ret && !send && (count == FULL);

  // Counter update; saturates at B on a spurious return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            count <= FULL;
    else if (send && !ret)                 count <= count - CW'(1);
    else if (ret && !send && count != FULL) count <= count + CW'(1);
  end
endmodule

module endp_flit_injector #(
  parameter int V    = 2,
  parameter int B    = 4,
  parameter int Fpay = 32,
  parameter int EAw  = 4,
  parameter int LENw = 4,
  localparam int VCw = (V > 1) ? $clog2(V) : 1,
  localparam int CW  = $clog2(B + 1),
  localparam int FW  = 2 + V + Fpay
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [EAw-1:0]  src_addr,
  input  logic            pkt_valid,
  output logic            pkt_ready,
  input  logic [EAw-1:0]  pkt_dest,
  input  logic [LENw-1:0] pkt_len,
  input  logic [VCw-1:0]  pkt_vc,
  input  logic            data_valid,
  output logic            data_ready,
  input  logic [Fpay-1:0] data_in,
  output logic [FW-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic [V-1:0]    credit_in,
  output logic            credit_err,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  typedef struct packed {
    logic [EAw-1:0]  dest;
    logic [LENw-1:0] len;
    logic [VCw-1:0]  vc;
  } req_t;

  state_t               state, state_nx;
  req_t                 req;
  logic [LENw-1:0]      remaining;
  logic [V-1:0][CW-1:0] credit;
  logic [V-1:0]         ovf_vec, send_vec, vc_oh;
  logic                 cred_ok, send_head, send;
  logic [Fpay-1:0]      head_pay;

  // One-hot VC select for the active packet.
  always_comb begin
    vc_oh = '0;
    for (int v = 0; v < V; v++) vc_oh[v] = (req.vc == VCw'(v));
  end

  // Gate only on the registered count of the active VC.
  assign cred_ok  = (credit[req.vc] != '0);
  assign send     = send_head | data_ready;
  assign send_vec = send ? vc_oh : '0;

  // Head payload: {len, dest, src} zero-extended, src in the LSBs.
  always_comb begin
    head_pay = '0;
    head_pay[2*EAw+LENw-1:0] = {req.len, req.dest, src_addr};
  end

  genvar g;
  generate
    for (g = 0; g < V; g++) begin : g_vc
      endp_credit_cnt #(.B(B), .CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .send  (send_vec[g]),
        .ret   (credit_in[g]),
        .count (credit[g]),
        .ovf   (ovf_vec[g])
      );
    end
  endgenerate

  // FSM next-state and handshake outputs.
  always_comb begin
    state_nx   = state;
    pkt_ready  = 1'b0;
    send_head  = 1'b0;
    data_ready = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) state_nx = HEAD;
      end
      HEAD: begin
        if (cred_ok) begin
          send_head = 1'b1;
          state_nx  = (req.len == '0) ? IDLE : BODY;
        end
      end
      BODY: begin
        if (data_valid && cred_ok) begin
          data_ready = 1'b1;
          if (remaining == LENw'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch and body-flit countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req       <= '0;
      remaining <= '0;
    end else begin
      if (state == IDLE && pkt_valid) req <= '{dest: pkt_dest, len: pkt_len, vc: pkt_vc};
      if (send_head)       remaining <= req.len;
      else if (data_ready) remaining <= remaining - LENw'(1);
    end
  end

  // Registered flit output; the bus holds its last flit between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      flit_out_wr <= send;
      if (send_head)       flit_out <= {1'b1, req.len == '0, vc_oh, head_pay};
      else if (data_ready) flit_out <= {1'b0, remaining == LENw'(1), vc_oh, data_in};
    end
  end

  // Sticky credit overflow flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        credit_err <= 1'b0;
    else if (|ovf_vec) credit_err <= 1'b1;
  end
endmodule

// File: tb/tb_endp_flit_injector.sv
// Directed bench for endp_flit_injector (V=2, B=4, Fpay=32, EAw=4, LENw=4).
module tb_endp_flit_injector;
  logic        clk, reset;
  logic [3:0]  src_addr, pkt_dest, pkt_len;
  logic        pkt_valid, pkt_ready, pkt_vc;
  logic        data_valid, data_ready;
  logic [31:0] data_in;
  logic [35:0] flit_out;
  logic        flit_out_wr, credit_err, busy;
  logic [1:0]  credit_in;

  int tests = 0;
  int fails = 0;

  endp_flit_injector #(.V(2), .B(4), .Fpay(32), .EAw(4), .LENw(4)) dut (
    .clk(clk), .reset(reset), .src_addr(src_addr),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest(pkt_dest),
    .pkt_len(pkt_len), .pkt_vc(pkt_vc),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_out(flit_out), .flit_out_wr(flit_out_wr),
    .credit_in(credit_in), .credit_err(credit_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] mk(input logic h, input logic t, input logic [1:0] oh,
                                     input logic [31:0] p);
    return {h, t, oh, p};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic refill(input int vc);
    credit_in = (vc == 0) ? 2'b01 : 2'b10;
    repeat (4) cyc();
    credit_in = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0; pkt_valid = 1'b1; data_valid = 1'b1;
    #3;
    tests++; if (flit_out_wr !== 1'b0) begin fails++; $display("FAIL reset_wr got %b want 0", flit_out_wr); end
    tests++; if (flit_out !== 36'h0) begin fails++; $display("FAIL reset_flit got %h want 0", flit_out); end
    tests++; if (pkt_ready !== 1'b1) begin fails++; $display("FAIL reset_pkt_ready got %b want 1", pkt_ready); end
    tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL reset_data_ready got %b want 0", data_ready); end
    tests++; if (credit_err !== 1'b0) begin fails++; $display("FAIL reset_credit_err got %b want 0", credit_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    cyc(); cyc();
    tests++; if (dut.credit !== {3'd4, 3'd4}) begin fails++; $display("FAIL reset_credits got %h want %h", dut.credit, {3'd4, 3'd4}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_hold_busy got %b want 0", busy); end
    pkt_valid = 1'b0; data_valid = 1'b0; reset = 1'b1;
    #1;
    tests++; if (pkt_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", pkt_ready); end
  endtask

  task automatic test_single();
    pkt_valid = 1'b1; pkt_dest = 4'd5; pkt_len = 4'd0; pkt_vc = 1'b1;
    #1;
    tests++; if (pkt_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b want 1", pkt_ready); end
    cyc(); pkt_valid = 1'b0; #1;
    tests++; if (busy !== 1'b1 || pkt_ready !== 1'b0) begin fails++; $display("FAIL single_head_state busy=%b ready=%b want 1 0", busy, pkt_ready); end
    tests++; if (flit_out_wr !== 1'b0) begin fails++; $display("FAIL single_early_wr got %b want 0", flit_out_wr); end
    cyc();
    tests++; if (flit_out_wr !== 1'b1 || flit_out !== mk(1, 1, 2'b10, 32'h053)) begin fails++; $display("FAIL single_flit wr=%b flit=%h want 1 %h", flit_out_wr, flit_out, mk(1, 1, 2'b10, 32'h053)); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", busy); end
    tests++; if (dut.credit[1] !== 3'd3) begin fails++; $display("FAIL single_credit got %0d want 3", dut.credit[1]); end
    cyc();
    tests++; if (flit_out_wr !== 1'b0) begin fails++; $display("FAIL single_one_flit got %b want 0", flit_out_wr); end
    credit_in = 2'b10; cyc(); credit_in = 2'b00;
    tests++; if (dut.credit[1] !== 3'd4) begin fails++; $display("FAIL single_return got %0d want 4", dut.credit[1]); end
  endtask

  task automatic test_body();
    logic [31:0] w [3];
    int dr;
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003;
    dr = 0;
    pkt_valid = 1'b1; pkt_dest = 4'hA; pkt_len = 4'd3; pkt_vc = 1'b0;
    data_valid = 1'b1; data_in = w[0];
    #1; if (data_ready) dr++;
    cyc(); pkt_valid = 1'b0; #1; if (data_ready) dr++;
    cyc();
    tests++; if (flit_out_wr !== 1'b1 || flit_out !== mk(1, 0, 2'b01, 32'h3A3)) begin fails++; $display("FAIL body_head wr=%b flit=%h want 1 %h", flit_out_wr, flit_out, mk(1, 0, 2'b01, 32'h3A3)); end
    for (int i = 0; i < 3; i++) begin
      data_in = w[i]; #1; if (data_ready) dr++;
      cyc();
      tests++; if (flit_out_wr !== 1'b1 || flit_out !== mk(0, i == 2, 2'b01, w[i])) begin fails++; $display("FAIL body_flit%0d wr=%b flit=%h want 1 %h", i, flit_out_wr, flit_out, mk(0, i == 2, 2'b01, w[i])); end
    end
    #1; if (data_ready) dr++;
    tests++; if (dr !== 3) begin fails++; $display("FAIL body_ready_cycles got %0d want 3", dr); end
    tests++; if (dut.credit[0] !== 3'd0) begin fails++; $display("FAIL body_credit got %0d want 0", dut.credit[0]); end
    data_valid = 1'b0;
    refill(0);
  endtask

  task automatic test_credit_exhaust();
    int n;
    pkt_valid = 1'b1; pkt_dest = 4'd2; pkt_len = 4'd6; pkt_vc = 1'b0;
    data_valid = 1'b1; data_in = 32'h1234_5678;
    cyc(); pkt_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin cyc(); if (flit_out_wr) n++; end
    tests++; if (n !== 4) begin fails++; $display("FAIL exhaust_first got %0d flits want 4", n); end
    #1;
    tests++; if (data_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL exhaust_stall ready=%b busy=%b want 0 1", data_ready, busy); end
    n = 0;
    for (int k = 0; k < 6; k++) begin
      credit_in = (k < 2) ? 2'b01 : 2'b00;
      cyc(); if (flit_out_wr) n++;
    end
    credit_in = 2'b00;
    tests++; if (n !== 2) begin fails++; $display("FAIL exhaust_refill got %0d flits want 2", n); end
    tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL exhaust_stall2 got %b want 0", data_ready); end
    credit_in = 2'b01; cyc(); credit_in = 2'b00; cyc();
    tests++; if (flit_out_wr !== 1'b1 || flit_out[35:34] !== 2'b01) begin fails++; $display("FAIL exhaust_tail wr=%b hdr_tail=%b want 1 01", flit_out_wr, flit_out[35:34]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL exhaust_busy got %b want 0", busy); end
    data_valid = 1'b0;
    refill(0);
  endtask

  task automatic test_simul();
    pkt_valid = 1'b1; pkt_dest = 4'd8; pkt_len = 4'd6; pkt_vc = 1'b1;
    data_valid = 1'b1; data_in = 32'h5555_AAAA;
    cyc(); pkt_valid = 1'b0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      credit_in = 2'b10; #1;
      tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL simul_ready%0d got %b want 1", i, data_ready); end
      cyc();
      tests++; if (flit_out_wr !== 1'b1 || dut.credit[1] !== 3'd3) begin fails++; $display("FAIL simul_step%0d wr=%b credit=%0d want 1 3", i, flit_out_wr, dut.credit[1]); end
    end
    credit_in = 2'b00; data_valid = 1'b0;
    tests++; if (busy !== 1'b0 || flit_out[34] !== 1'b1) begin fails++; $display("FAIL simul_tail busy=%b tail=%b want 0 1", busy, flit_out[34]); end
    credit_in = 2'b10; cyc(); credit_in = 2'b00;
    tests++; if (dut.credit[1] !== 3'd4 || credit_err !== 1'b0) begin fails++; $display("FAIL simul_full credit=%0d err=%b want 4 0", dut.credit[1], credit_err); end
    credit_in = 2'b10; cyc(); credit_in = 2'b00;
    tests++; if (credit_err !== 1'b1 || dut.credit[1] !== 3'd4) begin fails++; $display("FAIL simul_ovf err=%b credit=%0d want 1 4", credit_err, dut.credit[1]); end
    cyc(); cyc();
    tests++; if (credit_err !== 1'b1) begin fails++; $display("FAIL simul_sticky got %b want 1", credit_err); end
  endtask

  task automatic test_reset_mid();
    pkt_valid = 1'b1; pkt_dest = 4'd7; pkt_len = 4'd4; pkt_vc = 1'b0;
    data_valid = 1'b1; data_in = 32'hDEAD_BEEF;
    cyc(); pkt_valid = 1'b0;
    cyc(); cyc(); cyc();
    tests++; if (flit_out_wr !== 1'b1 || flit_out[34] !== 1'b0) begin fails++; $display("FAIL mid_pre wr=%b tail=%b want 1 0", flit_out_wr, flit_out[34]); end
    reset = 1'b0; #1;
    tests++; if (flit_out_wr !== 1'b0 || busy !== 1'b0 || pkt_ready !== 1'b1) begin fails++; $display("FAIL mid_abort wr=%b busy=%b ready=%b want 0 0 1", flit_out_wr, busy, pkt_ready); end
    tests++; if (dut.credit[0] !== 3'd4 || credit_err !== 1'b0) begin fails++; $display("FAIL mid_regs credit=%0d err=%b want 4 0", dut.credit[0], credit_err); end
    cyc(); cyc();
    tests++; if (flit_out_wr !== 1'b0) begin fails++; $display("FAIL mid_no_tail got %b want 0", flit_out_wr); end
    reset = 1'b1; cyc();
    tests++; if (pkt_ready !== 1'b1 || busy !== 1'b0 || flit_out_wr !== 1'b0) begin fails++; $display("FAIL mid_release ready=%b busy=%b wr=%b want 1 0 0", pkt_ready, busy, flit_out_wr); end
    tests++; if (dut.credit !== {3'd4, 3'd4}) begin fails++; $display("FAIL mid_credits got %h want %h", dut.credit, {3'd4, 3'd4}); end
    data_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    pkt_valid = 1'b1; pkt_dest = 4'd9; pkt_len = 4'd3; pkt_vc = 1'b0;
    data_valid = 1'b1; data_in = 32'hD0;
    cyc();
    pkt_dest = 4'd6; pkt_len = 4'd1; pkt_vc = 1'b1; #1;
    tests++; if (pkt_ready !== 1'b0) begin fails++; $display("FAIL b2b_no_accept got %b want 0", pkt_ready); end
    cyc();
    tests++; if (flit_out !== mk(1, 0, 2'b01, 32'h393)) begin fails++; $display("FAIL b2b_head0 got %h want %h", flit_out, mk(1, 0, 2'b01, 32'h393)); end
    cyc(); data_in = 32'hD1;
    tests++; if (flit_out !== mk(0, 0, 2'b01, 32'hD0)) begin fails++; $display("FAIL b2b_body0 got %h want %h", flit_out, mk(0, 0, 2'b01, 32'hD0)); end
    cyc(); data_in = 32'hD2;
    cyc(); data_in = 32'hD3;
    tests++; if (flit_out_wr !== 1'b1 || flit_out !== mk(0, 1, 2'b01, 32'hD2)) begin fails++; $display("FAIL b2b_tail0 wr=%b flit=%h want 1 %h", flit_out_wr, flit_out, mk(0, 1, 2'b01, 32'hD2)); end
    cyc(); pkt_valid = 1'b0;
    tests++; if (flit_out_wr !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_gap wr=%b busy=%b want 0 1", flit_out_wr, busy); end
    cyc();
    tests++; if (flit_out_wr !== 1'b1 || flit_out !== mk(1, 0, 2'b10, 32'h163)) begin fails++; $display("FAIL b2b_head1 wr=%b flit=%h want 1 %h", flit_out_wr, flit_out, mk(1, 0, 2'b10, 32'h163)); end
    cyc();
    tests++; if (flit_out_wr !== 1'b1 || flit_out !== mk(0, 1, 2'b10, 32'hD3)) begin fails++; $display("FAIL b2b_tail1 wr=%b flit=%h want 1 %h", flit_out_wr, flit_out, mk(0, 1, 2'b10, 32'hD3)); end
    tests++; if (dut.credit[0] !== 3'd0 || dut.credit[1] !== 3'd2) begin fails++; $display("FAIL b2b_credits c0=%0d c1=%0d want 0 2", dut.credit[0], dut.credit[1]); end
    data_valid = 1'b0;
    pkt_valid = 1'b1; pkt_dest = 4'd1; pkt_len = 4'd0; pkt_vc = 1'b0;
    cyc(); pkt_valid = 1'b0; credit_in = 2'b10;
    cyc();
    tests++; if (flit_out_wr !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_stall0 wr=%b busy=%b want 0 1", flit_out_wr, busy); end
    cyc(); credit_in = 2'b01;
    tests++; if (flit_out_wr !== 1'b0 || dut.credit[1] !== 3'd4) begin fails++; $display("FAIL b2b_vc1_indep wr=%b c1=%0d want 0 4", flit_out_wr, dut.credit[1]); end
    cyc(); credit_in = 2'b00;
    tests++; if (flit_out_wr !== 1'b0) begin fails++; $display("FAIL b2b_credit_latency got %b want 0", flit_out_wr); end
    cyc();
    tests++; if (flit_out_wr !== 1'b1 || flit_out !== mk(1, 1, 2'b01, 32'h013) || busy !== 1'b0) begin fails++; $display("FAIL b2b_late_head wr=%b flit=%h busy=%b want 1 %h 0", flit_out_wr, flit_out, busy, mk(1, 1, 2'b01, 32'h013)); end
    refill(0);
  endtask

  initial begin
    src_addr = 4'h3; pkt_valid = 1'b0; pkt_dest = '0; pkt_len = '0; pkt_vc = 1'b0;
    data_valid = 1'b0; data_in = '0; credit_in = '0; reset = 1'b0;
    test_reset();
    test_single();
    test_body();
    test_credit_exhaust();
    test_simul();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/endp_flit_injector.md
# endp_flit_injector

Endpoint-side packet injector for one local router port of the mesh/torus/ring/line NoC. It accepts packet requests and a stream of payload words from the endpoint and serializes them into head/body/tail flits on the channel into the router. It performs per-VC credit-based flow control against the router's input buffers. It is the transmitting end of the endpoint-to-router channel whose receiving end is the router local port.

## Interface
- `V`, default 2: number of virtual channels.
- `B`, default 4: router input buffer depth per VC, in flits; also the initial credit count.
- `Fpay`, default 32: flit payload width. Must be ≥ 2*`EAw`+`LENw`.
- `EAw`, default 4: endpoint address width.
- `LENw`, default 4: packet body-length field width.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `src_addr` input, `EAw` bits: this endpoint's address. Static.
- `pkt_valid` input, 1 bit: packet request present.
- `pkt_ready` output, 1 bit: injector can accept a request.
- `pkt_dest` input, `EAw` bits: destination endpoint address.
- `pkt_len` input, `LENw` bits: number of body flits, 0..2^`LENw`-1.
- `pkt_vc` input, `log2(V)` bits: VC to use.
- `data_valid` input, 1 bit: payload word present.
- `data_ready` output, 1 bit: payload word consumed this cycle.
- `data_in` input, `Fpay` bits: payload word.
- `flit_out` output, 2+`V`+`Fpay` bits. Fields are {hdr, tail, vc_onehot[V], payload}.
- `flit_out_wr` output, 1 bit: `flit_out` valid; one-cycle pulse per flit.
- `credit_in` input, `V` bits: one-cycle credit-return pulse per VC.
- `credit_err` output, 1 bit: sticky; set when a credit counter would exceed `B`.
- `busy` output, 1 bit: high when the state is not IDLE.

## Operation
- There are three states: IDLE, HEAD and BODY.
- In IDLE, `pkt_ready`=1. On `pkt_valid`&&`pkt_ready`, latch `pkt_dest`, `pkt_len` and `pkt_vc`, then go to HEAD.
- In HEAD, emit the head flit when `credit[vc]`>0.
  - Head flit fields: hdr=1, tail=(len==0), vc_onehot=1<<vc.
  - Head payload = zero-extended {len, dest, src_addr}. `src_addr` occupies the LSBs.
  - If len==0, return to IDLE. Otherwise go to BODY with `remaining`=len.
- In BODY, `data_ready` = `data_valid` && `credit[vc]`>0.
  - On `data_ready`, emit a body flit: hdr=0, tail=(`remaining`==1), payload=`data_in`.
  - Decrement `remaining`. When the tail flit is emitted, return to IDLE.
- If `credit[vc]`==0, the FSM stalls in HEAD or BODY. No flit is emitted, and `data_ready` is held at 0.
- Credit counters: one per VC, width log2(`B`+1) bits, reset value `B`.
  - A flit sent on VC v decrements `credit[v]`.
  - A `credit_in[v]` pulse increments `credit[v]`.
  - Both in the same cycle leave the count unchanged.
  - An increment at `B` (with no send) saturates at `B` and sets `credit_err`.
- Credits for VCs other than the active one keep updating while a packet is in progress.
- A new request is never accepted while in HEAD or BODY. Packets are never interleaved.

## Timing
- Reset values: `flit_out_wr`=0, `flit_out`=0, `pkt_ready`=1, `data_ready`=0, `credit_err`=0, `busy`=0. All credits = `B`. State = IDLE.
- Reset asserted mid-packet aborts the packet immediately. No tail is emitted. After reset deasserts, state is IDLE.
- `flit_out` and `flit_out_wr` are registered. A flit emitted at clock edge N is visible with `flit_out_wr`=1 during the cycle following edge N.
- A request accepted at edge N gives state HEAD after edge N. With credit available, the head is emitted at edge N+1 and `flit_out_wr` is high in the next cycle.
- Body flits stream at one per cycle while `data_valid` and credits allow. Full throughput when `B` ≥ credit round-trip.
- `pkt_ready`, `data_ready` and `busy` are combinational from state, registers and `data_valid`.
- The credit check uses the registered counter value. A credit arriving in cycle N is usable at the next edge.
- Minimum gap between packets: 1 cycle, for the IDLE re-accept.

## Test plan
- **Reset and single-flit packet.** Reset with `V`=2, `B`=4. Send request dest=5, len=0, vc=1.
  - Expect exactly one flit: hdr=1, tail=1, vc_onehot=2'b10, payload={0,5,src}.
  - Expect `credit[1]`=3 and `busy` low again one cycle later.
- **Body streaming.** Send len=3 with `data_valid` held high and data A,B,C.
  - Expect flits head, A, B, C in 4 consecutive cycles, with tail only on C.
  - Expect `data_ready` high for exactly 3 cycles.
- **Credit exhaustion.** Use `B`=4, len=6, no `credit_in`.
  - Expect exactly 4 flits, then a stall with `data_ready`=0.
  - Pulse `credit_in[vc]` twice: exactly 2 more flits are emitted, with the count verified.
- **Simultaneous send and credit.** Return credits every cycle while streaming.
  - Expect the counter to stay constant and no stall.
  - Inject an extra `credit_in` while the counter is at `B`: expect `credit_err`=1 to stay set.
- **Reset mid-packet.** Assert `reset` during BODY with `remaining`=2.
  - Expect `flit_out_wr`=0 immediately, with no tail.
  - After release, expect `pkt_ready`=1 and credits = `B`.
- **Back-to-back packets on different VCs.** Check vc_onehot per flit. Check per-VC credit independence: VC0 at 0 credits must not block VC1.
